// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers line/frame timing from async syncs,
// locks after LOCK_FRAMES good frames and emits active-area pixels.
//
// Ports:
//   clk, rst_n            pixel clock, synchronous active-low reset
//   hsync_in, vsync_in    asynchronous active-low sync inputs
//   pixel_in[2:0]         RGB sample aligned with the sync inputs
//   rx_x, rx_y [9:0]      active-area coordinate of rx_pixel
//   rx_pixel[2:0]         pixel delayed 3 clocks, 0 when not valid
//   rx_valid              active-area pixel while locked
//   frame_start           one-cycle pulse per vsync falling edge
//   locked                timing locked
// Optional (VGA_RX_TIMING_OUT_EN):
//   meas_h_total[10:0]    last captured line length
//   meas_v_total[9:0]     last captured frame length
module vga_sync_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_START     = 144,
    parameter int V_START     = 35,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [2:0]  pixel_in,
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic [2:0]  rx_pixel,
    output logic        rx_valid,
    output logic        frame_start,
    output logic        locked
`ifdef VGA_RX_TIMING_OUT_EN
    ,
    output logic [10:0] meas_h_total,
    output logic [9:0]  meas_v_total
`endif
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int GW = $clog2(LOCK_FRAMES + 1);

    localparam logic [10:0] H_LO   = 11'(H_START);
    localparam logic [10:0] H_HI   = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] H_LOSS = 11'(2 * H_TOTAL);
    localparam logic [11:0] H_LEN  = 12'(H_TOTAL);
    localparam logic [9:0]  V_LO   = 10'(V_START);
    localparam logic [9:0]  V_HI   = 10'(V_START + V_ACTIVE);
    localparam logic [10:0] V_LEN  = 11'(V_TOTAL);

    logic          hs_s1, hs_s2, hs_prev;
    logic          vs_s1, vs_s2, vs_prev;
    logic [2:0]    pix_d1, pix_d2;
    logic [10:0]   h_cnt, h_cur;
    logic [9:0]    v_cnt, v_cur;
    logic [11:0]   h_len;
    logic [10:0]   v_len;
    logic          h_edge, v_edge;
    logic          h_bad, v_ok, line_bad, frame_good;
    logic          sync_loss, active, valid_n;
    state_t        state, state_n;
    logic [GW-1:0] good_cnt, good_n, good_inc;

    // Two-stage synchronizer plus one more stage for edge detect;
    // the pixel takes the same two-stage path so it stays aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_s1   <= 1'b1;
            hs_s2   <= 1'b1;
            hs_prev <= 1'b1;
            vs_s1   <= 1'b1;
            vs_s2   <= 1'b1;
            vs_prev <= 1'b1;
            pix_d1  <= 3'b000;
            pix_d2  <= 3'b000;
        end else begin
            hs_s1   <= hsync_in;
            hs_s2   <= hs_s1;
            hs_prev <= hs_s2;
            vs_s1   <= vsync_in;
            vs_s2   <= vs_s1;
            vs_prev <= vs_s2;
            pix_d1  <= pixel_in;
            pix_d2  <= pix_d1;
        end
    end

    assign h_edge = hs_prev & ~hs_s2;
    assign v_edge = vs_prev & ~vs_s2;

    // Lengths are taken from the count before the edge clears it.
    assign h_len = {1'b0, h_cnt} + 12'd1;
    assign v_len = {1'b0, v_cnt} + 11'd1;

    assign h_bad      = h_edge & (h_len != H_LEN);
    assign v_ok       = (v_len == V_LEN);
    // The line ending on a coincident edge belongs to the closing frame.
    assign frame_good = ~line_bad & ~h_bad & v_ok;

    // Position of the pixel currently leaving the alignment pipe.
    assign h_cur = h_edge ? 11'd0 :
                   (&h_cnt) ? h_cnt : h_cnt + 11'd1;
    assign v_cur = v_edge ? 10'd0 :
                   (h_edge & ~(&v_cnt)) ? v_cnt + 10'd1 : v_cnt;

    assign sync_loss = (h_cur == H_LOSS);
    assign good_inc  = good_cnt + GW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt    <= 11'd0;
            v_cnt    <= 10'd0;
            line_bad <= 1'b0;
        end else begin
            h_cnt <= h_cur;
            v_cnt <= v_cur;
            if (v_edge) begin
                line_bad <= 1'b0;
            end else if (h_bad) begin
                line_bad <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_n;
            good_cnt <= good_n;
        end
    end

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        unique case (state)
            SEARCH: begin
                if (v_edge) begin
                    state_n = ACQUIRE;
                    good_n  = '0;
                end
            end
            ACQUIRE: begin
                if (v_edge) begin
                    if (frame_good) begin
                        good_n = good_inc;
                        if (good_inc == GW'(LOCK_FRAMES)) begin
                            state_n = LOCKED;
                        end
                    end else begin
                        good_n = '0;
                    end
                end
            end
            LOCKED: begin
                if (h_bad || (v_edge && !v_ok) || sync_loss) begin
                    state_n = SEARCH;
                end
            end
            default: begin
                state_n = SEARCH;
                good_n  = '0;
            end
        endcase
    end

    assign active  = (h_cur >= H_LO) && (h_cur < H_HI) &&
                     (v_cur >= V_LO) && (v_cur < V_HI);
    // Uses the next state so a drop out of LOCKED blanks at once.
    assign valid_n = active && (state_n == LOCKED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_x        <= 10'd0;
            rx_y        <= 10'd0;
            rx_pixel    <= 3'b000;
            rx_valid    <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
        end else begin
            rx_x        <= active ? 10'(h_cur - H_LO) : 10'd0;
            rx_y        <= active ? (v_cur - V_LO) : 10'd0;
            rx_pixel    <= valid_n ? pix_d2 : 3'b000;
            rx_valid    <= valid_n;
            frame_start <= v_edge;
            locked      <= (state_n == LOCKED);
        end
    end

`ifdef VGA_RX_TIMING_OUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meas_h_total <= 11'd0;
            meas_v_total <= 10'd0;
        end else begin
            if (h_edge) begin
                meas_h_total <= h_len[11] ? 11'h7FF : h_len[10:0];
            end
            if (v_edge) begin
                meas_v_total <= v_len[10] ? 10'h3FF : v_len[9:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver: reduced timing, random pixels/noise,
// behavioural model compared every cycle plus literal spot checks.
module tb_vga_sync_receiver;

    localparam int HT  = 40;
    localparam int VT  = 12;
    localparam int HS  = 8;
    localparam int VS  = 3;
    localparam int HA  = 24;
    localparam int VA  = 6;
    localparam int LF  = 2;
    localparam int HSW = 4;
    localparam int VSW = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic [2:0] pixel_in = 3'b000;
    logic [9:0] rx_x, rx_y;
    logic [2:0] rx_pixel;
    logic       rx_valid, frame_start, locked;
`ifdef VGA_RX_TIMING_OUT_EN
    logic [10:0] meas_h_total;
    logic [9:0]  meas_v_total;
`endif

    always #5 clk = ~clk;

    vga_sync_receiver #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS),
        .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hsync_in(hsync_in),
        .vsync_in(vsync_in),
        .pixel_in(pixel_in),
        .rx_x(rx_x),
        .rx_y(rx_y),
        .rx_pixel(rx_pixel),
        .rx_valid(rx_valid),
        .frame_start(frame_start),
        .locked(locked)
`ifdef VGA_RX_TIMING_OUT_EN
        ,
        .meas_h_total(meas_h_total),
        .meas_v_total(meas_v_total)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [2:0] px;
    } smp_t;

    smp_t q[$];
    int   m_h, m_v, m_mode, m_good;
    bit   m_lbad, m_ph, m_pv, m_init = 0, last_rst = 0;
    int   e_x, e_y, e_px, e_val, e_fs, e_lk, e_mh, e_mv;

    // Input samples reach the decision point two clocks late; the
    // queue starts with two idle samples to model that.
    always @(posedge clk) begin : model
        smp_t s;
        bit   hf, vf, hb, act;
        int   len, flen, nh, nv;
        if (!rst_n) begin
            s.hs = 1'b1; s.vs = 1'b1; s.px = 3'b000;
            q.delete();
            q.push_back(s);
            q.push_back(s);
            m_h = 0; m_v = 0; m_mode = 0; m_good = 0;
            m_lbad = 0; m_ph = 1; m_pv = 1;
            e_x = 0; e_y = 0; e_px = 0; e_val = 0;
            e_fs = 0; e_lk = 0; e_mh = 0; e_mv = 0;
            m_init = 1; last_rst = 1;
        end else begin
            last_rst = 0;
            s.hs = hsync_in; s.vs = vsync_in; s.px = pixel_in;
            q.push_back(s);
            s = q.pop_front();
            hf = !s.hs && m_ph;
            vf = !s.vs && m_pv;
            m_ph = s.hs;
            m_pv = s.vs;
            len  = m_h + 1;
            flen = m_v + 1;
            hb   = hf && (len != HT);
            nh   = hf ? 0 : imin(m_h + 1, 2047);
            nv   = vf ? 0 : (hf ? imin(m_v + 1, 1023) : m_v);
            if (hf) e_mh = imin(len, 2047);
            if (vf) e_mv = imin(flen, 1023);
            case (m_mode)
                0: if (vf) begin m_mode = 1; m_good = 0; end
                1: if (vf) begin
                    if (!m_lbad && !hb && flen == VT) begin
                        m_good++;
                        if (m_good == LF) m_mode = 2;
                    end else begin
                        m_good = 0;
                    end
                end
                default:
                    if (hb || (vf && flen != VT) || nh == 2 * HT)
                        m_mode = 0;
            endcase
            if (vf) m_lbad = 0;
            else if (hb) m_lbad = 1;
            m_h = nh;
            m_v = nv;
            act = nh >= HS && nh < HS + HA && nv >= VS && nv < VS + VA;
            e_x   = act ? nh - HS : 0;
            e_y   = act ? nv - VS : 0;
            e_val = (act && m_mode == 2) ? 1 : 0;
            e_px  = e_val ? int'(s.px) : 0;
            e_fs  = vf ? 1 : 0;
            e_lk  = (m_mode == 2) ? 1 : 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    int fs_cnt = 0;
    bit seen_valid = 0;

    always @(negedge clk) begin
        if (m_init) begin
            chk("rx_x", rx_x, e_x);
            chk("rx_y", rx_y, e_y);
            chk("rx_pixel", rx_pixel, e_px);
            chk("rx_valid", rx_valid, e_val);
            chk("frame_start", frame_start, e_fs);
            chk("locked", locked, e_lk);
`ifdef VGA_RX_TIMING_OUT_EN
            chk("meas_h", meas_h_total, e_mh);
            chk("meas_v", meas_v_total, e_mv);
`endif
            if (last_rst) begin
                chk("rst_valid", rx_valid, 0);
                chk("rst_locked", locked, 0);
                chk("rst_fs", frame_start, 0);
            end
            if (frame_start) fs_cnt++;
            if (!locked) begin
                seen_valid = 0;
            end else if (rx_valid && !seen_valid) begin
                seen_valid = 1;
                chk("first_valid_x", rx_x, 0);
                chk("first_valid_y", rx_y, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(bit hs, bit vs, logic [2:0] px);
        @(posedge clk);
        #1;
        hsync_in = hs;
        vsync_in = vs;
        pixel_in = px;
    endtask

    task automatic zchk(string tag);
        chk({tag, "_x"}, rx_x, 0);
        chk({tag, "_y"}, rx_y, 0);
        chk({tag, "_pix"}, rx_pixel, 0);
        chk({tag, "_valid"}, rx_valid, 0);
        chk({tag, "_fs"}, frame_start, 0);
        chk({tag, "_locked"}, locked, 0);
`ifdef VGA_RX_TIMING_OUT_EN
        chk({tag, "_mh"}, meas_h_total, 0);
        chk({tag, "_mv"}, meas_v_total, 0);
`endif
    endtask

    task automatic rst_pulse(int n);
        rst_n = 1'b0;
        repeat (n) cyc(1'b1, 1'b1, 3'b000);
        rst_n = 1'b1;
    endtask

    // Pixel driven at (line V_START, h H_START) shows up 3 clocks later.
    task automatic pin_check();
        repeat (3) @(posedge clk);
        #1;
        chk("pin_pixel", rx_pixel, 5);
        chk("pin_valid", rx_valid, 1);
        chk("pin_x", rx_x, 0);
        chk("pin_y", rx_y, 0);
    endtask

    task automatic drive_line(int len, int li, bit vlow, bit hpulse,
                              bit pin, int rpos);
        bit         rl;
        logic [2:0] px;
        rl = 0;
        for (int p = 0; p < len; p++) begin
            if (li == VS && p == HS) px = 3'b101;
            else px = 3'($urandom_range(0, 7));
            cyc(!(hpulse && p < HSW), !vlow, px);
            if (rl) begin
                rst_n = 1'b1;
                rl = 0;
                zchk("midrst");
            end
            if (p == rpos) begin
                rst_n = 1'b0;
                rl = 1;
            end
            if (pin && li == VS && p == HS) begin
                fork
                    pin_check();
                join_none
            end
        end
    endtask

    task automatic frame(int short_l, bit pin);
        for (int l = 0; l < VT; l++)
            drive_line((l == short_l) ? HT - 1 : HT, l, l < VSW,
                       1'b1, pin, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_pulse(3);
        zchk("por");

        for (int f = 0; f < 3; f++) begin
            int n;
            n = $urandom_range(VT - 2, VT + 2);
            for (int l = 0; l < n; l++)
                drive_line($urandom_range(HT - 3, HT + 3), l, l < VSW,
                           1'b1, 1'b0, -1);
        end

        rst_pulse(2);
        zchk("rst2");
        frame(-1, 1'b0);
        frame(-1, 1'b0);
        chk("lock_before_3rd", locked, 0);
        frame(-1, 1'b1);
        chk("lock_after_3rd", locked, 1);
`ifdef VGA_RX_TIMING_OUT_EN
        chk("meas_h_std", meas_h_total, HT);
        chk("meas_v_std", meas_v_total, VT);
`endif

        frame(5, 1'b1);
        chk("short_unlock", locked, 0);
        chk("short_valid", rx_valid, 0);
        frame(-1, 1'b0);
        frame(-1, 1'b0);
        chk("short_relock_early", locked, 0);
        frame(-1, 1'b1);
        chk("short_relock", locked, 1);

        for (int l = 0; l < VT; l++) begin
            if (l == 5) drive_line(2 * HT + 10, l, 1'b0, 1'b0, 1'b0, -1);
            else drive_line(HT, l, l < VSW, 1'b1, 1'b1, -1);
        end
        chk("loss_unlock", locked, 0);
        fs_cnt = 0;
        frame(-1, 1'b0);
        chk("fs_after_loss", fs_cnt, 1);
        chk("loss_still_unlocked", locked, 0);
        frame(-1, 1'b0);
        frame(-1, 1'b1);
        chk("loss_relock", locked, 1);

        for (int l = 0; l < VT; l++)
            drive_line(HT, l, l < VSW, 1'b1, 1'b1, (l == 5) ? 20 : -1);
        frame(-1, 1'b0);
        frame(-1, 1'b0);
        chk("rst_relock_early", locked, 0);
        frame(-1, 1'b1);
        chk("rst_relock", locked, 1);

        repeat (4) cyc(1'b1, 1'b1, 3'b000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 Parameter H_TOTAL, 800: expected clocks per line.
REQ-002 Parameter V_TOTAL, 525: expected lines per frame.
REQ-003 Parameter H_START, 144: clocks from hsync falling edge to first active pixel.
REQ-004 Parameter V_START, 35: lines from vsync falling edge to first active line.
REQ-005 Parameter H_ACTIVE, 640 / V_ACTIVE, 480: active width and height.
REQ-006 Parameter LOCK_FRAMES, 2: consecutive good frames required to lock.
REQ-007 clk  input  1  pixel clock; the block has one clock, and all logic is on its rising edge.
REQ-008 rst_n  input  1  reset; synchronous and active-low.
REQ-009 hsync_in / vsync_in  input  1 each  asynchronous sync inputs, active-low.
REQ-010 pixel_in  input  3  RGB sample, qualified by the sync timing.
REQ-011 rx_x / rx_y  output  10 each  active-area coordinate of rx_pixel.
REQ-012 rx_pixel  output  3  delayed pixel; 3'b000 when rx_valid=0.
REQ-013 rx_valid  output  1  high for active-area pixels while locked.
REQ-014 frame_start  output  1  one-cycle pulse on each synchronized vsync falling edge.
REQ-015 locked  output  1  high in state LOCKED.

Function
REQ-016 hsync_in and vsync_in pass through a 2-FF synchronizer; pixel_in is delayed 2 cycles to stay aligned.
REQ-017 A falling edge is synchronized value 0 with previous synchronized value 1.
REQ-018 h_cnt (11 bit): 0 in the hsync-edge cycle, +1 otherwise, saturating at 2047.
REQ-019 v_cnt (10 bit): +1 on hsync edge; 0 on vsync edge (vsync has priority on a coincident edge); saturates at 1023.
REQ-020 Line length = h_cnt+1, captured on each hsync edge; frame length = v_cnt+1, captured on each vsync edge.
REQ-021 States: SEARCH (reset), ACQUIRE, LOCKED; 2-bit encoding.
REQ-022 SEARCH -> ACQUIRE on the first vsync edge; good-frame count is cleared.
REQ-023 ACQUIRE: a frame is good if every captured line length = H_TOTAL and the frame length = V_TOTAL.
REQ-024 ACQUIRE: on each vsync edge, a good frame increments the count; a bad frame clears it.
REQ-025 ACQUIRE -> LOCKED on the vsync edge where the count reaches LOCK_FRAMES.
REQ-026 LOCKED -> SEARCH on any line-length mismatch, any frame-length mismatch, or h_cnt reaching 2*H_TOTAL (sync loss).
REQ-027 Pixel active when H_START <= h_cnt < H_START+H_ACTIVE and V_START <= v_cnt < V_START+V_ACTIVE.
REQ-028 rx_x = h_cnt-H_START and rx_y = v_cnt-V_START; both are 0 when not active.
REQ-029 rx_valid = active AND locked.
REQ-030 All outputs are registered.
REQ-031 Latency from pixel_in to rx_pixel is 3 clocks, matched to sync timing.
REQ-032 frame_start is registered in the same cycle as the v_cnt clear.
REQ-033 frame_start pulses in every state.
REQ-034 Falling from LOCKED deasserts rx_valid on the next clock.
REQ-035 A partial line (early hsync) is a mismatch; the counters restart from the new edge.

Reset
REQ-036 While rst_n=0 at a clock edge: state=SEARCH.
REQ-037 While rst_n=0 at a clock edge: h_cnt, v_cnt, good count, synchronizers (to 1), rx_x, rx_y, rx_pixel, rx_valid, frame_start and locked are all cleared.
REQ-038 Reset mid-frame discards all measurements; re-lock needs a fresh vsync plus LOCK_FRAMES good frames.

Configuration
REQ-039 With VGA_RX_TIMING_OUT_EN defined, add output meas_h_total (11 bit), the last captured line length.
REQ-040 With VGA_RX_TIMING_OUT_EN defined, add output meas_v_total (10 bit), the last captured frame length.
REQ-041 meas_h_total and meas_v_total reset to 0 and update in every state.
REQ-042 Without VGA_RX_TIMING_OUT_EN, these ports and their registers are absent; all other behaviour is identical.

Verification
REQ-043 Reset, then standard 800x525 timing for 3 frames -> locked rises at the 3rd vsync edge; first rx_valid shows rx_x=0, rx_y=0.
REQ-044 Locked; pixel_in=3'b101 at h_cnt 144, line 35 -> rx_pixel=3'b101, rx_valid=1, rx_x=0, rx_y=0.
REQ-045 Locked; one line of 799 clocks -> locked=0 and rx_valid=0 on the next clock; re-lock after 1 vsync plus 2 good frames.
REQ-046 Locked; hsync held high for 1600 clocks -> SEARCH; frame_start still pulses on later vsync edges.
REQ-047 Coincident hsync and vsync edges -> h_cnt=0 and v_cnt=0; with VGA_RX_TIMING_OUT_EN, meas_v_total=525 and meas_h_total=800.
REQ-048 rst_n low for 1 clock mid-frame while locked -> all outputs 0 next cycle; re-lock after 3 vsync edges.
